// File: rtl/phy_tx_serializer_if.sv
// rtl/phy_tx_serializer_if.sv - byte stream handshake into the PHY transmit serializer
interface phy_tx_serializer_if;
    logic [7:0] tx_d;
    logic       tx_dv;
    logic       tx_last;
    logic       tx_rdy;

    modport master (output tx_d, output tx_dv, output tx_last, input tx_rdy);
    modport slave  (input tx_d, input tx_dv, input tx_last, output tx_rdy);
endinterface

// File: rtl/phy_tx_serializer.sv
// rtl/phy_tx_serializer.sv - byte FIFO to MII/RMII symbol serializer with preamble, IFG and underrun abort
module phy_tx_serializer #(
    parameter int PHY_WIDTH   = 4,
    parameter int CLK_DIV     = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int START_LEVEL = 8,
    parameter int IFG_BYTES   = 12,
    parameter int PREAMBLE_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    phy_tx_serializer_if.slave   tx,
    output logic                 phy_ce,
    output logic [PHY_WIDTH-1:0] phy_txd,
    output logic                 phy_tx_en,
    output logic                 phy_tx_er,
    output logic                 underrun,
    output logic                 busy
);

    localparam int SYM      = 8 / PHY_WIDTH;
    localparam int SW       = $clog2(SYM);
    localparam int IFG_SYMS = IFG_BYTES * SYM;
    localparam int CW       = $clog2(IFG_SYMS + 8) + 1;
    localparam int DW       = $clog2(CLK_DIV);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int LW       = AW + 1;
    localparam bit USE_PRE  = (PREAMBLE_EN != 0);
    localparam logic [7:0] PRE_FIRST = 8'h55;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_ERR, S_DROP, S_IFG} state_t;

    state_t         state;
    logic [DW-1:0]  div;
    logic [SW-1:0]  sym;
    logic [CW-1:0]  cnt;
    logic [7:0]     sh;
    logic           cur_last;
    logic           drop_done;

    logic [8:0]     mem [FIFO_DEPTH];
    logic [LW-1:0]  wr_ptr, rd_ptr, level, frame_cnt;
    logic [8:0]     rd_word;
    logic           rd_last, full, empty;

    logic           dropping, accept, discard, push, pop;
    logic           byte_end, start_cond, ifg_done, want_data;
    logic           load_data, under_hit, drop_pop, drop_hit;
    logic [7:0]     pre_byte;

    // Symbol-rate divider, free running from reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div <= '0;
        else if (div == DW'(CLK_DIV - 1))
            div <= '0;
        else
            div <= div + DW'(1);
    end

    assign phy_ce = (div == DW'(CLK_DIV - 1));
    assign busy   = (state != S_IDLE);

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == LW'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign rd_word = mem[rd_ptr[AW-1:0]];
    assign rd_last = rd_word[8];

    // While aborting, input that arrives with the FIFO already drained belongs to the
    // dead frame and is swallowed; anything queued behind FIFO contents keeps its order.
    assign dropping  = ((state == S_ERR) || (state == S_DROP)) && !drop_done;
    assign tx.tx_rdy = rst_n && (((state == S_DROP) && !drop_done) || !full);
    assign accept    = tx.tx_dv && tx.tx_rdy;
    assign discard   = accept && dropping && empty;
    assign push      = accept && !discard;

    assign byte_end   = (sym == SW'(SYM - 1));
    assign start_cond = (level >= LW'(START_LEVEL)) || (frame_cnt != '0);
    assign ifg_done   = (cnt == CW'(IFG_SYMS - 1));
    assign pre_byte   = (cnt == CW'(6)) ? 8'hD5 : 8'h55;

    // Decide whether this strobe must begin a new payload byte
    always_comb begin
        want_data = 1'b0;
        case (state)
            S_IDLE:  want_data = !USE_PRE && start_cond;
            S_IFG:   want_data = !USE_PRE && ifg_done && start_cond;
            S_PRE:   want_data = byte_end && (cnt == CW'(7));
            S_DATA:  want_data = byte_end && !cur_last;
            default: want_data = 1'b0;
        endcase
    end

    assign load_data = phy_ce && want_data && !empty;
    assign under_hit = phy_ce && want_data && empty;
    assign drop_pop  = dropping && !empty;
    assign pop       = load_data || drop_pop;
    assign drop_hit  = (drop_pop && rd_last) || (discard && tx.tx_last);

    // FIFO storage, written only on accepted non-discarded input
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {tx.tx_last, tx.tx_d};
    end

    // FIFO pointers and count of complete frames held in the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frame_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + LW'(1);
            if (pop)
                rd_ptr <= rd_ptr + LW'(1);
            case ({push && tx.tx_last, pop && rd_last})
                2'b10:   frame_cnt <= frame_cnt + LW'(1);
                2'b01:   frame_cnt <= frame_cnt - LW'(1);
                default: frame_cnt <= frame_cnt;
            endcase
        end
    end

    // Transmit state machine; PHY outputs only move on symbol strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sym       <= '0;
            cnt       <= '0;
            sh        <= '0;
            cur_last  <= 1'b0;
            drop_done <= 1'b0;
            phy_txd   <= '0;
            phy_tx_en <= 1'b0;
            phy_tx_er <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= under_hit;
            if (drop_hit)
                drop_done <= 1'b1;
            if (phy_ce) begin
                if (load_data) begin
                    state     <= S_DATA;
                    sym       <= '0;
                    cur_last  <= rd_last;
                    phy_txd   <= rd_word[PHY_WIDTH-1:0];
                    sh        <= rd_word[7:0] >> PHY_WIDTH;
                    phy_tx_en <= 1'b1;
                    phy_tx_er <= 1'b0;
                end else if (under_hit) begin
                    state     <= S_ERR;
                    sym       <= '0;
                    drop_done <= 1'b0;
                    phy_txd   <= '0;
                    phy_tx_en <= 1'b1;
                    phy_tx_er <= 1'b1;
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (USE_PRE && start_cond) begin
                                state     <= S_PRE;
                                cnt       <= '0;
                                sym       <= '0;
                                phy_txd   <= PRE_FIRST[PHY_WIDTH-1:0];
                                sh        <= PRE_FIRST >> PHY_WIDTH;
                                phy_tx_en <= 1'b1;
                                phy_tx_er <= 1'b0;
                            end
                        end
                        S_PRE, S_DATA: begin
                            if (!byte_end) begin
                                sym     <= sym + SW'(1);
                                phy_txd <= sh[PHY_WIDTH-1:0];
                                sh      <= sh >> PHY_WIDTH;
                            end else if (state == S_PRE) begin
                                cnt     <= cnt + CW'(1);
                                sym     <= '0;
                                phy_txd <= pre_byte[PHY_WIDTH-1:0];
                                sh      <= pre_byte >> PHY_WIDTH;
                            end else begin
                                state     <= S_IFG;
                                cnt       <= '0;
                                phy_txd   <= '0;
                                phy_tx_en <= 1'b0;
                                phy_tx_er <= 1'b0;
                            end
                        end
                        S_ERR: begin
                            if (!byte_end) begin
                                sym <= sym + SW'(1);
                            end else begin
                                state     <= (drop_done || drop_hit) ? S_IFG : S_DROP;
                                cnt       <= '0;
                                phy_txd   <= '0;
                                phy_tx_en <= 1'b0;
                                phy_tx_er <= 1'b0;
                            end
                        end
                        S_DROP: begin
                            if (drop_done) begin
                                state <= S_IFG;
                                cnt   <= '0;
                            end
                        end
                        S_IFG: begin
                            if (!ifg_done) begin
                                cnt <= cnt + CW'(1);
                            end else if (USE_PRE && start_cond) begin
                                state     <= S_PRE;
                                cnt       <= '0;
                                sym       <= '0;
                                phy_txd   <= PRE_FIRST[PHY_WIDTH-1:0];
                                sh        <= PRE_FIRST >> PHY_WIDTH;
                                phy_tx_en <= 1'b1;
                                phy_tx_er <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
